// File: rtl/serial_loader.sv
// serial_loader: boot-frame loader sitting between the Serial mem port and
// the program RAM write port. Polls the Serial flags, drains rx bytes one at
// a time, parses MAGIC/addr/count/data/checksum and writes 32-bit words.
// Optional feature macro: LOADER_ACK_EN (send an ack byte after the checksum).
module serial_loader #(
    parameter int         ADDR_W  = 18,
    parameter logic [7:0] MAGIC   = 8'hA5,
    parameter logic [7:0] ACK_OK  = 8'h06,
    parameter logic [7:0] ACK_ERR = 8'h15
) (
    input  logic              memClk,
    input  logic              memRst,
    input  logic              enable,
    output logic              serClkEn,
    output logic              serWE,
    output logic [17:0]       serAddr,
    output logic [31:0]       serData,
    input  logic [31:0]       serQ,
    output logic              progWE,
    output logic [ADDR_W-1:0] progAddr,
    output logic [31:0]       progData,
    output logic              busy,
    output logic              done,
    output logic              err
);

    typedef enum logic [2:0] {
        S_IDLE, S_RX_POLL, S_RX_RD, S_RX_CAP, S_TX_POLL, S_TX_WR, S_DONE
    } state_t;

    typedef enum logic [2:0] {
        P_HUNT, P_ADDR, P_CNT, P_DATA, P_CSUM
    } phase_t;

    localparam logic [17:0] SER_TX    = 18'd0;
    localparam logic [17:0] SER_RX    = 18'd1;
    localparam logic [17:0] SER_FLAGS = 18'd2;

    state_t              state_q, state_d;
    phase_t              phase_q, phase_d;
    logic [1:0]          idx_q, idx_d;            // byte index within addr/cnt/word
    logic [31:0]         addr_q, addr_d;          // little-endian load address
    logic [15:0]         cnt_q, cnt_d;            // word count N
    logic [15:0]         word_idx_q, word_idx_d;  // words written so far
    logic [23:0]         word_q, word_d;          // first three bytes of a data word
    logic [7:0]          sum_q, sum_d;            // running checksum
    logic                err_q, err_d;
    logic                prog_we_q, prog_we_d;
    logic [ADDR_W-1:0]   prog_addr_q, prog_addr_d;
    logic [31:0]         prog_data_q, prog_data_d;

    // The byte is consumed straight off serQ at the capture edge; the parser
    // registers below are its stored form.
    logic [7:0]  rx_byte;
    logic [31:0] addr_sum;
    logic [15:0] word_next;

    assign rx_byte   = serQ[7:0];
    assign addr_sum  = addr_q + {16'd0, word_idx_q};
    assign word_next = word_idx_q + 16'd1;

    // Sequencer and frame parser next-state, plus Serial-side strobes.
    always_comb begin
        // NOTE: every output and next-state gets a default first so no path
        // through the case statements leaves a latch behind.
        state_d     = state_q;
        phase_d     = phase_q;
        idx_d       = idx_q;
        addr_d      = addr_q;
        cnt_d       = cnt_q;
        word_idx_d  = word_idx_q;
        word_d      = word_q;
        sum_d       = sum_q;
        err_d       = err_q;
        prog_we_d   = 1'b0;
        prog_addr_d = prog_addr_q;
        prog_data_d = prog_data_q;
        serClkEn    = 1'b0;
        serWE       = 1'b0;
        serAddr     = SER_FLAGS;
        serData     = 32'd0;

        case (state_q)
            S_IDLE: begin
                if (enable) begin
                    state_d    = S_RX_POLL;
                    phase_d    = P_HUNT;
                    err_d      = 1'b0;
                    idx_d      = 2'd0;
                    sum_d      = 8'd0;
                    word_idx_d = 16'd0;
                end
            end
            S_RX_POLL: begin
                if (!serQ[2]) state_d = S_RX_RD;
            end
            S_RX_RD: begin
                serAddr  = SER_RX;
                serClkEn = 1'b1;
                state_d  = S_RX_CAP;
            end
            S_RX_CAP: begin
                serAddr = SER_RX;
                state_d = S_RX_POLL;
                case (phase_q)
                    P_HUNT: begin
                        if (rx_byte == MAGIC) begin
                            phase_d = P_ADDR;
                            idx_d   = 2'd0;
                            sum_d   = 8'd0;
                        end
                    end
                    P_ADDR: begin
                        sum_d  = sum_q + rx_byte;
                        addr_d = {rx_byte, addr_q[31:8]};
                        idx_d  = idx_q + 2'd1;
                        if (idx_q == 2'd3) begin
                            phase_d = P_CNT;
                            idx_d   = 2'd0;
                        end
                    end
                    P_CNT: begin
                        sum_d = sum_q + rx_byte;
                        cnt_d = {rx_byte, cnt_q[15:8]};
                        idx_d = idx_q + 2'd1;
                        if (idx_q == 2'd1) begin
                            idx_d      = 2'd0;
                            word_idx_d = 16'd0;
                            phase_d    = ({rx_byte, cnt_q[15:8]} == 16'd0) ? P_CSUM : P_DATA;
                        end
                    end
                    P_DATA: begin
                        sum_d  = sum_q + rx_byte;
                        word_d = {rx_byte, word_q[23:8]};
                        idx_d  = idx_q + 2'd1;
                        if (idx_q == 2'd3) begin
                            prog_we_d   = 1'b1;
                            prog_addr_d = addr_sum[ADDR_W-1:0];
                            prog_data_d = {rx_byte, word_q};
                            word_idx_d  = word_next;
                            if (word_next == cnt_q) phase_d = P_CSUM;
                        end
                    end
                    P_CSUM: begin
                        err_d   = (rx_byte != sum_q);
                        phase_d = P_HUNT;
`ifdef LOADER_ACK_EN
                        state_d = S_TX_POLL;
`else
                        state_d = S_DONE;
`endif
                    end
                    default: phase_d = P_HUNT;
                endcase
            end
`ifdef LOADER_ACK_EN
            S_TX_POLL: begin
                if (!serQ[0]) state_d = S_TX_WR;
            end
            S_TX_WR: begin
                serAddr  = SER_TX;
                serWE    = 1'b1;
                serClkEn = 1'b1;
                serData  = {24'd0, err_q ? ACK_ERR : ACK_OK};
                state_d  = S_DONE;
            end
`endif
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge memClk) begin
        // NOTE: sequential state uses non-blocking assignments only, so every
        // register samples the pre-edge value of every other register.
        if (memRst) begin
            state_q     <= S_IDLE;
            phase_q     <= P_HUNT;
            idx_q       <= 2'd0;
            addr_q      <= 32'd0;
            cnt_q       <= 16'd0;
            word_idx_q  <= 16'd0;
            word_q      <= 24'd0;
            sum_q       <= 8'd0;
            err_q       <= 1'b0;
            prog_we_q   <= 1'b0;
            prog_addr_q <= '0;
            prog_data_q <= 32'd0;
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            idx_q       <= idx_d;
            addr_q      <= addr_d;
            cnt_q       <= cnt_d;
            word_idx_q  <= word_idx_d;
            word_q      <= word_d;
            sum_q       <= sum_d;
            err_q       <= err_d;
            prog_we_q   <= prog_we_d;
            prog_addr_q <= prog_addr_d;
            prog_data_q <= prog_data_d;
        end
    end

    assign progWE   = prog_we_q;
    assign progAddr = prog_addr_q;
    assign progData = prog_data_q;
    assign err      = err_q;
    assign done     = (state_q == S_DONE);
    assign busy     = (state_q != S_IDLE) && (state_q != S_DONE);

    // Bits that do not feed any logic in every build configuration.
    logic unused_ok;
    assign unused_ok = ^{serQ[31:8], serQ[0], addr_sum[31:ADDR_W], ACK_OK, ACK_ERR};

endmodule

// File: tb/tb_serial_loader.sv
// Testbench for serial_loader: behavioural Serial model (rx FIFO with
// registered read data, flags, tx capture) plus scoreboards for program
// writes and ack bytes. Honours LOADER_ACK_EN the same way as the design.
module tb_serial_loader;

    localparam int ADDR_W = 18;

    logic              memClk = 1'b0;
    logic              memRst = 1'b1;
    logic              enable = 1'b0;
    logic              serClkEn, serWE;
    logic [17:0]       serAddr;
    logic [31:0]       serData;
    logic [31:0]       serQ;
    logic              progWE;
    logic [ADDR_W-1:0] progAddr;
    logic [31:0]       progData;
    logic              busy, done, err;

    serial_loader #(.ADDR_W(ADDR_W)) dut (
        .memClk(memClk), .memRst(memRst), .enable(enable),
        .serClkEn(serClkEn), .serWE(serWE), .serAddr(serAddr),
        .serData(serData), .serQ(serQ),
        .progWE(progWE), .progAddr(progAddr), .progData(progData),
        .busy(busy), .done(done), .err(err)
    );

    always #5 memClk = ~memClk;

    int checks   = 0;
    int failures = 0;

    // Serial model state
    logic [7:0]  rx_fifo[$];
    logic [7:0]  rx_data_q = 8'd0;
    logic        rx_hold   = 1'b0;
    logic        rx_empty  = 1'b1;
    logic        tx_full   = 1'b0;
    int          rd_count  = 0;
    logic [7:0]  fsum;

    // Scoreboards: {progAddr, progData} and ack bytes
    logic [ADDR_W+31:0] exp_wr[$];
    logic [7:0]         exp_ack[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Serial rx FIFO: a read strobe pops the head into the rxData register.
    always @(posedge memClk) begin
        if (serClkEn && !serWE && serAddr == 18'd1) begin
            rd_count <= rd_count + 1;
            if (rx_fifo.size() > 0) rx_data_q <= rx_fifo.pop_front();
        end
    end

    // Flags are refreshed between edges.
    always @(negedge memClk) rx_empty <= rx_hold || (rx_fifo.size() == 0);

    always_comb begin
        serQ = 32'd0;
        if (serAddr == 18'd2)      serQ = {29'd0, rx_empty, 1'b0, tx_full};
        else if (serAddr == 18'd1) serQ = {24'd0, rx_data_q};
    end

    // Program-write scoreboard
    always @(negedge memClk) begin
        if (progWE === 1'b1) begin
            check("progwe_expected", 64'(exp_wr.size() != 0), 64'd1);
            if (exp_wr.size() != 0)
                check("progwe_addr_data", 64'({progAddr, progData}), 64'(exp_wr.pop_front()));
        end
    end

    // Ack-byte scoreboard
    always @(negedge memClk) begin
        if (serClkEn === 1'b1 && serWE === 1'b1) begin
            check("ack_expected", 64'(exp_ack.size() != 0), 64'd1);
            check("ack_addr", 64'(serAddr), 64'd0);
            if (exp_ack.size() != 0)
                check("ack_byte", 64'(serData), 64'(exp_ack.pop_front()));
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired before summary");
        $fatal(1, "watchdog");
    end

    task automatic put_sum(input logic [7:0] b);
        rx_fifo.push_back(b);
        fsum = fsum + b;
    endtask

    task automatic put_hdr(input logic [31:0] addr, input logic [15:0] n);
        rx_fifo.push_back(8'hA5);
        fsum = 8'd0;
        for (int i = 0; i < 4; i++) put_sum(addr[8*i +: 8]);
        for (int i = 0; i < 2; i++) put_sum(n[8*i +: 8]);
    endtask

    task automatic put_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++) put_sum(w[8*i +: 8]);
    endtask

    task automatic put_frame1(input logic good);
        put_hdr(32'h0000_0010, 16'd2);
        put_word(32'h1122_3344);
        put_word(32'hDEAD_BEEF);
        rx_fifo.push_back(good ? fsum : 8'h00);
    endtask

    task automatic expect_frame1(input logic good);
        exp_wr.push_back({18'h00010, 32'h1122_3344});
        exp_wr.push_back({18'h00011, 32'hDEAD_BEEF});
`ifdef LOADER_ACK_EN
        exp_ack.push_back(good ? 8'h06 : 8'h15);
`endif
    endtask

    task automatic start();
        @(negedge memClk);
        enable = 1'b1;
        @(negedge memClk);
        enable = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int n = 0;
        while (done !== 1'b1 && n < budget) begin
            @(negedge memClk);
            n++;
        end
        check({tag, "_done_seen"}, 64'(done), 64'd1);
        check({tag, "_busy_at_done"}, 64'(busy), 64'd0);
        @(negedge memClk);
        check({tag, "_done_pulse"}, 64'(done), 64'd0);
    endtask

    task automatic check_drained(input string tag);
        check({tag, "_writes_left"}, 64'(exp_wr.size()), 64'd0);
        check({tag, "_acks_left"}, 64'(exp_ack.size()), 64'd0);
    endtask

    initial begin
        int n;
        int rd_before;

        // Reset state
        repeat (3) @(negedge memClk);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_err", 64'(err), 64'd0);
        check("rst_progwe", 64'(progWE), 64'd0);
        check("rst_seraddr", 64'(serAddr), 64'd2);
        check("rst_serclken", 64'(serClkEn), 64'd0);
        check("rst_serwe", 64'(serWE), 64'd0);
        memRst = 1'b0;

        // 1: happy path
        expect_frame1(1'b1);
        put_frame1(1'b1);
        start();
        check("t1_busy", 64'(busy), 64'd1);
        wait_done("t1", 300);
        check("t1_err", 64'(err), 64'd0);
        check_drained("t1");

        // 2: bad checksum, writes still land, err sticky while idle
        expect_frame1(1'b0);
        put_frame1(1'b0);
        start();
        wait_done("t2", 300);
        check("t2_err", 64'(err), 64'd1);
        repeat (3) @(negedge memClk);
        check("t2_err_sticky", 64'(err), 64'd1);
        check_drained("t2");

        // 3: hunt past junk; err cleared when enable is accepted
        rx_fifo.push_back(8'h00);
        rx_fifo.push_back(8'hFF);
        rx_fifo.push_back(8'h5A);
        expect_frame1(1'b1);
        put_frame1(1'b1);
        start();
        check("t3_err_cleared", 64'(err), 64'd0);
        wait_done("t3", 300);
        check("t3_err", 64'(err), 64'd0);
        check_drained("t3");

        // 4: empty frame, no writes
        put_hdr(32'h0000_0020, 16'd0);
        rx_fifo.push_back(fsum);
`ifdef LOADER_ACK_EN
        exp_ack.push_back(8'h06);
`endif
        start();
        wait_done("t4", 200);
        check("t4_err", 64'(err), 64'd0);
        check_drained("t4");

        // 5: address wrap at 2^ADDR_W
        exp_wr.push_back({18'h3FFFF, 32'h0102_0304});
        exp_wr.push_back({18'h00000, 32'hA0B0_C0D0});
`ifdef LOADER_ACK_EN
        exp_ack.push_back(8'h06);
`endif
        put_hdr(32'h0003_FFFF, 16'd2);
        put_word(32'h0102_0304);
        put_word(32'hA0B0_C0D0);
        rx_fifo.push_back(fsum);
        start();
        wait_done("t5", 300);
        check("t5_err", 64'(err), 64'd0);
        check_drained("t5");

        // 6a: rx empty flag holds off every read; tx full stalls the ack
        rx_hold = 1'b1;
        tx_full = 1'b1;
        expect_frame1(1'b1);
        put_frame1(1'b1);
        rd_before = rd_count;
        start();
        repeat (30) @(negedge memClk);
        check("t6_no_read", 64'(rd_count - rd_before), 64'd0);
        check("t6_busy_hold", 64'(busy), 64'd1);
        check("t6_poll_addr", 64'(serAddr), 64'd2);
        rx_hold = 1'b0;
`ifdef LOADER_ACK_EN
        n = 0;
        while (exp_wr.size() != 0 && n < 300) begin
            @(negedge memClk);
            n++;
        end
        repeat (40) @(negedge memClk);
        check("t6_ack_stalled", 64'(exp_ack.size()), 64'd1);
        check("t6_no_done", 64'(done), 64'd0);
        check("t6_busy_stall", 64'(busy), 64'd1);
        tx_full = 1'b0;
`else
        tx_full = 1'b0;
`endif
        wait_done("t6", 400);
        check_drained("t6");

        // 6b: reset in the middle of the data phase
        exp_wr.push_back({18'h00010, 32'h1122_3344});
        put_frame1(1'b1);
        start();
        n = 0;
        while (exp_wr.size() != 0 && n < 300) begin
            @(negedge memClk);
            n++;
        end
        check("t6r_first_word", 64'(exp_wr.size()), 64'd0);
        @(negedge memClk);
        memRst = 1'b1;
        @(posedge memClk);
        #1;
        check("t6r_busy", 64'(busy), 64'd0);
        check("t6r_progwe", 64'(progWE), 64'd0);
        check("t6r_seraddr", 64'(serAddr), 64'd2);
        @(negedge memClk);
        memRst = 1'b0;
        rx_fifo.delete();

        // 7: clean frame after the abort
        expect_frame1(1'b1);
        put_frame1(1'b1);
        start();
        wait_done("t7", 300);
        check("t7_err", 64'(err), 64'd0);
        check_drained("t7");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
